// File: rtl/reg_access_pkg.sv
// Shared opcode and FSM state encodings for the register access arbiter.
// Opcodes match the per-requester op slices driven by the requesters.
package reg_access_pkg;

  localparam logic [1:0] OP_LOAD   = 2'b00;
  localparam logic [1:0] OP_CLEAR  = 2'b01;
  localparam logic [1:0] OP_PRESET = 2'b10;
  localparam logic [1:0] OP_NOP    = 2'b11;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_EXEC = 2'b01;
  localparam logic [1:0] ST_DONE = 2'b10;

endpackage

// File: rtl/reg_access_arbiter_rr_pick.sv
// Combinational round-robin picker: searches req starting at the index after
// ptr, wrapping at NREQ-1, and returns the first hit as one-hot plus index.
module rr_pick #(
  parameter int NREQ = 4,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic [NREQ-1:0] onehot,
  output logic [PW-1:0]   idx,
  output logic            valid
);

  localparam int CW = PW + 1;

  logic [CW-1:0] cand;
  logic [PW-1:0] cand_idx;

  always_comb begin
    onehot   = '0;
    idx      = '0;
    valid    = 1'b0;
    cand     = '0;
    cand_idx = '0;
    for (int k = 0; k < NREQ; k++) begin
      // ptr+1+k never exceeds 2*NREQ-1, so one subtraction wraps it
      cand = {1'b0, ptr} + CW'(k + 1);
      if (cand >= CW'(NREQ))
        cand = cand - CW'(NREQ);
      cand_idx = cand[PW-1:0];
      if (!valid && req[cand_idx]) begin
        valid            = 1'b1;
        idx              = cand_idx;
        onehot[cand_idx] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_access_arbiter.sv
// Round-robin arbiter granting NREQ requesters single-operation access to a
// shared WIDTH-bit register (load / clear / preset / nop) via IDLE-EXEC-DONE.
module reg_access_arbiter
  import reg_access_pkg::*;
#(
  parameter int               NREQ       = 4,
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] PRESET_VAL = {WIDTH{1'b1}}
) (
  input  logic                  clk,
  input  logic                  clr,
  input  logic [NREQ-1:0]       req,
  input  logic [2*NREQ-1:0]     op,
  input  logic [WIDTH*NREQ-1:0] wdata,
  output logic [NREQ-1:0]       gnt,
  output logic                  ack,
  output logic [WIDTH-1:0]      q,
  output logic                  busy
);

  localparam int PW = $clog2(NREQ);

  logic [1:0]       op_arr    [NREQ];
  logic [WIDTH-1:0] wdata_arr [NREQ];

  genvar gi;
  generate
    for (gi = 0; gi < NREQ; gi++) begin : g_slice
      assign op_arr[gi]    = op[2*gi +: 2];
      assign wdata_arr[gi] = wdata[WIDTH*gi +: WIDTH];
    end
  endgenerate

  logic [1:0]       state_reg, state_next;
  logic [PW-1:0]    ptr_reg;
  logic [NREQ-1:0]  gnt_reg;
  logic             ack_reg;
  logic             busy_reg;
  logic [WIDTH-1:0] q_reg, q_next;
  logic [1:0]       op_reg;
  logic [WIDTH-1:0] wdata_reg;

  logic [NREQ-1:0]  pick_onehot;
  logic [PW-1:0]    pick_idx;
  logic             pick_valid;

  rr_pick #(
    .NREQ (NREQ),
    .PW   (PW)
  ) u_rr_pick (
    .req    (req),
    .ptr    (ptr_reg),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .valid  (pick_valid)
  );

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (pick_valid) state_next = ST_EXEC;
      ST_EXEC: state_next = ST_DONE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Only the latched op/wdata are used, so inputs may change once granted
  always_comb begin
    q_next = q_reg;
    case (op_reg)
      OP_LOAD:   q_next = wdata_reg;
      OP_CLEAR:  q_next = '0;
      OP_PRESET: q_next = PRESET_VAL;
      OP_NOP:    q_next = q_reg;
      default:   q_next = q_reg;
    endcase
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_reg <= ST_IDLE;
      ptr_reg   <= PW'(NREQ - 1);
      gnt_reg   <= '0;
      ack_reg   <= 1'b0;
      busy_reg  <= 1'b0;
      q_reg     <= '0;
      op_reg    <= OP_NOP;
      wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      busy_reg  <= (state_next != ST_IDLE);
      case (state_reg)
        ST_IDLE: begin
          ack_reg <= 1'b0;
          if (pick_valid) begin
            gnt_reg   <= pick_onehot;
            ptr_reg   <= pick_idx;
            op_reg    <= op_arr[pick_idx];
            wdata_reg <= wdata_arr[pick_idx];
          end else begin
            gnt_reg <= '0;
          end
        end
        ST_EXEC: begin
          q_reg   <= q_next;
          ack_reg <= 1'b1;
        end
        default: begin
          ack_reg <= 1'b0;
          gnt_reg <= '0;
        end
      endcase
    end
  end

  assign gnt  = gnt_reg;
  assign ack  = ack_reg;
  assign q    = q_reg;
  assign busy = busy_reg;

endmodule

// File: tb/tb_reg_access_arbiter.sv
// Directed self-checking bench for reg_access_arbiter (NREQ=4, WIDTH=8).
// Inputs change after the falling edge; outputs are sampled 1ns after rising.
module tb_reg_access_arbiter;

  logic        clk;
  logic        clr;
  logic [3:0]  req;
  logic [7:0]  op;
  logic [31:0] wdata;
  logic [3:0]  gnt;
  logic        ack;
  logic [7:0]  q;
  logic        busy;

  int n_cmp;
  int n_bad;

  reg_access_arbiter #(
    .NREQ       (4),
    .WIDTH      (8),
    .PRESET_VAL (8'hFF)
  ) dut (
    .clk   (clk),
    .clr   (clr),
    .req   (req),
    .op    (op),
    .wdata (wdata),
    .gnt   (gnt),
    .ack   (ack),
    .q     (q),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_op(input int i, input logic [1:0] o, input logic [7:0] d);
    op[2*i +: 2]    = o;
    wdata[8*i +: 8] = d;
  endtask

  // Expects grant in EXEC, then q and ack in DONE, then idle with gnt cleared
  task automatic txn(input string tag, input logic [3:0] exp_gnt, input logic [7:0] exp_q,
                     input logic [3:0] req_after);
    tick();
    chk({tag, "_gnt"}, 32'(gnt), 32'(exp_gnt));
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_noack"}, 32'(ack), 32'd0);
    tick();
    chk({tag, "_ack"}, 32'(ack), 32'd1);
    chk({tag, "_q"}, 32'(q), 32'(exp_q));
    chk({tag, "_gnthold"}, 32'(gnt), 32'(exp_gnt));
    $display("txn %s: gnt=%b q=%h ack=%b", tag, gnt, q, ack);
    @(negedge clk);
    req = req_after;
    tick();
    chk({tag, "_idlegnt"}, 32'(gnt), 32'd0);
    chk({tag, "_idleack"}, 32'(ack), 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    clr   = 1'b1;
    req   = 4'b0000;
    op    = 8'hFF;
    wdata = 32'h0;
    #12;
    chk("rst_q", 32'(q), 32'h00);
    chk("rst_gnt", 32'(gnt), 32'h0);
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    @(negedge clk);
    clr = 1'b0;
    tick();
    chk("idle_gnt", 32'(gnt), 32'h0);
    chk("idle_busy", 32'(busy), 32'h0);

    // Simultaneous 0 and 3 after reset: 0 first, then 3
    @(negedge clk);
    req = 4'b1001;
    txn("sim0", 4'b0001, 8'h00, 4'b1000);
    txn("sim3", 4'b1000, 8'h00, 4'b0000);

    // Sole requester 2 loads A5
    @(negedge clk);
    set_op(2, 2'b00, 8'hA5);
    req = 4'b0100;
    txn("load2", 4'b0100, 8'hA5, 4'b0000);

    // Preset from 1, then clear from 3
    @(negedge clk);
    set_op(1, 2'b10, 8'h11);
    req = 4'b0010;
    tick();
    chk("pre_gnt", 32'(gnt), 32'b0010);
    tick();
    chk("pre_q", 32'(q), 32'hFF);
    chk("pre_ack", 32'(ack), 32'd1);
    @(negedge clk);
    set_op(3, 2'b01, 8'h77);
    req = 4'b1000;
    tick();
    txn("clr3", 4'b1000, 8'h00, 4'b0000);

    // Load 3C from 0; wdata changed and req dropped while in EXEC
    @(negedge clk);
    set_op(0, 2'b00, 8'h3C);
    req = 4'b0001;
    tick();
    chk("late_gnt", 32'(gnt), 32'b0001);
    @(negedge clk);
    set_op(0, 2'b00, 8'hC3);
    req = 4'b0000;
    tick();
    chk("late_q", 32'(q), 32'h3C);
    chk("late_ack", 32'(ack), 32'd1);
    tick();
    chk("late_qhold", 32'(q), 32'h3C);
    chk("late_busy", 32'(busy), 32'd0);

    // All requesting nop; pointer sits at 0 so rotation starts at 1
    @(negedge clk);
    op  = 8'hFF;
    req = 4'b1111;
    txn("rot1", 4'b0010, 8'h3C, 4'b1111);
    txn("rot2", 4'b0100, 8'h3C, 4'b1111);
    txn("rot3", 4'b1000, 8'h3C, 4'b1111);
    txn("rot0", 4'b0001, 8'h3C, 4'b1111);
    txn("rot1b", 4'b0010, 8'h3C, 4'b0000);

    // Reset mid-EXEC aborts a load of 5A
    @(negedge clk);
    set_op(0, 2'b00, 8'h5A);
    req = 4'b0001;
    tick();
    chk("abort_gnt", 32'(gnt), 32'b0001);
    #2;
    clr = 1'b1;
    #1;
    chk("abort_q", 32'(q), 32'h00);
    chk("abort_ack", 32'(ack), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_gnt0", 32'(gnt), 32'd0);
    @(negedge clk);
    clr = 1'b0;
    op  = 8'hFF;
    req = 4'b1111;
    tick();
    chk("post_q", 32'(q), 32'h00);
    chk("post_ack", 32'(ack), 32'd0);
    chk("post_gnt", 32'(gnt), 32'b0001);
    tick();
    chk("post_ack1", 32'(ack), 32'd1);

    // Sole requester 2 wins back-to-back arbitrations
    @(negedge clk);
    req = 4'b0100;
    tick();
    txn("sole_a", 4'b0100, 8'h00, 4'b0100);
    txn("sole_b", 4'b0100, 8'h00, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/reg_access_arbiter.md
REG_ACCESS_ARBITER -- requirements
Module: reg_access_arbiter

Interface
REQ-001 The block SHALL have parameter NREQ, default 4, setting the number of requesters (2..8).
REQ-002 The block SHALL have parameter WIDTH, default 8, setting the shared register width.
REQ-003 The block SHALL have parameter PRESET_VAL, default all-ones of WIDTH, setting the value written by the preset op.
REQ-004 Port clk  input  1  rising-edge clock.
REQ-005 Port clr  input  1  reset, asynchronous, active-high.
REQ-006 Port req  input  NREQ  per-requester access request, level, held until ack.
REQ-007 Port op  input  2*NREQ  per-requester opcode, slice i = bits [2i+1:2i]: 00 load, 01 clear, 10 preset, 11 nop/read.
REQ-008 Port wdata  input  WIDTH*NREQ  per-requester load data, slice i = bits [WIDTH*i+WIDTH-1:WIDTH*i].
REQ-009 Port gnt  output  NREQ  one-hot grant, all-zero when idle.
REQ-010 Port ack  output  1  single-cycle completion pulse for the granted requester.
REQ-011 Port q  output  WIDTH  shared register contents.
REQ-012 Port busy  output  1  high whenever state is not IDLE.

Function
REQ-013 The FSM SHALL have states IDLE, EXEC, DONE; all outputs registered.
REQ-014 IDLE: when any req bit is high, the block SHALL select one winner round-robin, starting at the index after the last winner and wrapping from NREQ-1 to 0, latch that requester's op and wdata, set gnt one-hot, and go to EXEC.
REQ-015 IDLE with req all-zero SHALL remain in IDLE with gnt=0.
REQ-016 EXEC: on the exiting edge q SHALL take wdata (load), 0 (clear), PRESET_VAL (preset), or hold (nop); the state SHALL go to DONE.
REQ-017 DONE: ack SHALL be 1 for exactly this cycle, gnt held; next state IDLE, where gnt clears.
REQ-018 Latency: req sampled at edge N -> gnt high N+1 -> q updated at edge N+2 -> ack high between edges N+2 and N+3.
REQ-019 op and wdata SHALL be sampled only in IDLE at grant; later changes SHALL NOT affect the operation in flight.
REQ-020 A req dropped during EXEC/DONE SHALL NOT abort the operation; ack SHALL still be issued.
REQ-021 A req still high in the IDLE cycle after DONE SHALL be treated as a new request, arbitrated with the pointer already advanced past it.
REQ-022 The round-robin pointer SHALL update only on entry to EXEC, to the winner index.
REQ-023 With all req high continuously, grants SHALL rotate 0,1,...,NREQ-1,0 with no requester granted twice before every other has been granted once.
REQ-024 A sole active requester SHALL be granted on every arbitration in which it requests.
REQ-025 q SHALL change only in EXEC or on clr.

Reset
REQ-026 clr high SHALL immediately force state IDLE, q=0, gnt=0, ack=0, busy=0, pointer=NREQ-1 (requester 0 highest priority first).
REQ-027 clr asserted during EXEC or DONE SHALL abort the operation with no ack and no q update.
REQ-028 After clr deasserts, the first arbitration SHALL occur at the first clk rising edge.

Structure
REQ-029 A package reg_access_pkg SHALL hold opcode constants (OP_LOAD, OP_CLEAR, OP_PRESET, OP_NOP) and the state encoding.
REQ-030 One combinational sub-module rr_pick SHALL compute the one-hot winner from req and the pointer; FSM, latches and q remain in reg_access_arbiter.

Verification
REQ-031 clr pulse mid-EXEC with op=load, wdata=8'h5A -> q=8'h00, no ack, busy=0 immediately.
REQ-032 Only req[2], op=00, wdata=8'hA5 -> gnt=4'b0100 one cycle later, q=8'hA5 and ack one cycle after that.
REQ-033 req=4'b1111 held, all op=nop -> gnt sequence 0001,0010,0100,1000,0001; one ack per grant, q unchanged.
REQ-034 req[1] op=10 then req[3] op=01 -> q=8'hFF after first ack, 8'h00 after second.
REQ-035 req[0] load 8'h3C; wdata[0] changed to 8'hC3 during EXEC, req[0] dropped in EXEC -> q=8'h3C, ack still issued.
REQ-036 After reset, req=4'b1001 simultaneous -> requester 0 granted first, requester 3 next.
